dram_access_master: RTL and testbench
=====================================

// Module: dram_access_master
// PURPOSE
//   Initiator side of the single-port DRAM interface (write_en/addr/data_in -> data_out, 1-cycle read).
//   Arbitrates memory requests from NUM_CORES cores round-robin, issues at most one access per cycle,
//   tracks in-flight reads and routes read data back to the requesting core. Sits between cores and DRAM.
// PARAMETERS
//   NUM_CORES  4     number of requesting cores (>=2)
//   ADDR_W     16    address width, matches DRAM addr
//   DATA_W     16    data width, matches DRAM data_in/data_out
//   MEM_DEPTH  1025  valid words; addresses >= MEM_DEPTH are out of range (OOB)
// PORTS
//   clk          in   1                 rising-edge clock
//   rst_n        in   1                 asynchronous active-low reset
//   req_valid    in   NUM_CORES         per-core request valid
//   req_ready    out  NUM_CORES         per-core grant; one-hot or zero
//   req_we       in   NUM_CORES         1=write, 0=read
//   req_addr     in   NUM_CORES*ADDR_W  packed, core i at [i*ADDR_W +: ADDR_W]
//   req_wdata    in   NUM_CORES*DATA_W  packed write data
//   resp_valid   out  NUM_CORES         one-cycle read-response pulse to the owning core
//   resp_err     out  1                 qualifies resp_valid: read was OOB
//   resp_rdata   out  DATA_W            shared read data, 0 when no response or OOB
//   oob_cnt      out  16                saturating count of accepted OOB requests
//   mem_write_en out  1                 to DRAM write_en
//   mem_addr     out  ADDR_W            to DRAM addr
//   mem_data_in  out  DATA_W            to DRAM data_in
//   mem_data_out in   DATA_W            from DRAM data_out
// BEHAVIOUR
//   Reset: all registered outputs 0, rr pointer 0, pipeline valid bits 0, oob_cnt 0. Reset mid-operation
//     drops all in-flight reads; no response is produced for them after release.
//   Arbitration: req_ready combinational from req_valid and rr pointer; first valid core at or after the
//     pointer wins. On grant to core k, pointer <= (k+1) mod NUM_CORES; no valid -> pointer unchanged.
//   Accept edge E0 (valid & ready): mem_write_en <= req_we & in-range; mem_addr <= req_addr;
//     mem_data_in <= req_wdata. Idle cycle: mem_write_en <= 0, mem_addr/mem_data_in hold (harmless read).
//   Writes: no response. In-range write lands in DRAM at E1. OOB write: mem_write_en stays 0, oob_cnt++.
//   Reads: stage1 {v,core,err} loaded at E0, stage2 <= stage1 at E1 (DRAM updates data_out at E1).
//     Cycle after E1: resp_valid[core]=1, resp_err=err, resp_rdata = err ? 0 : mem_data_out.
//     Read latency = 2 edges from accept; back-to-back reads give one response per cycle.
//   Write-then-read same address in consecutive cycles returns the new data (DRAM writes at E1, read at E2).
//   oob_cnt saturates at 16'hFFFF. No backpressure on responses: cores must accept resp_valid always.
// CONFIGURATION
//   RESP_REG_EN defined: resp_valid/resp_err/resp_rdata registered one more edge (latency 3, reset 0).
//   Undefined: responses decoded combinationally from stage2 regs and mem_data_out (latency 2).
// STRUCTURE
//   Package dram_pkg: ADDR_W, DATA_W, MEM_DEPTH constants; core-index typedef; rd_tag_t struct {v,core,err}.
//   Sub-module rr_arbiter (NUM_CORES): req_valid, advance -> one-hot grant, registered pointer.
// TESTING
//   Core0 write addr 10 data 16'h00AB, then core0 read addr 10 -> resp_valid[0] 2 cycles after accept, rdata 16'h00AB.
//   All 4 cores valid reads every cycle for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in same order.
//   Core2 read addr 1025 -> resp_err=1, rdata=0, oob_cnt=1; core1 write addr 2000 -> no DRAM write, oob_cnt=2.
//   Read addr 5 issued, rst_n low for 1 cycle before response -> no resp_valid after release; outputs 0.
//   Idle after write -> mem_write_en=0, mem_addr holds; with RESP_REG_EN read latency measured 3.
//   Core1 write addr 7 = 16'h1234 next cycle core3 read addr 7 -> resp_valid[3], rdata 16'h1234.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: shared constants and types for dram_access_master and rr_arbiter
package dram_pkg;
  localparam int NUM_CORES = 4;
  localparam int CORE_W    = $clog2(NUM_CORES);
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 1025;
  typedef logic [CORE_W-1:0] core_t;
  typedef struct packed {
    logic  v;
    core_t core;
    logic  err;
  } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, first valid requester at or after the pointer wins
//   clk, rst_n  clock, asynchronous active-low reset
//   req_valid   per-requester request
//   advance     move the pointer past the winner this cycle
//   grant       one-hot (or zero) grant, combinational
//   grant_idx   index of the granted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr_q, ptr_d;
  logic found;
  int idx;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = W'(idx);
        ptr_d = advance ? W'((idx + 1) % N) : ptr_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/dram_access_master.sv
// dram_access_master: round-robin DRAM initiator for NUM_CORES cores with read-response routing
//   req_valid/req_ready/req_we/req_addr/req_wdata  per-core request handshake (packed buses)
//   resp_valid/resp_err/resp_rdata                 read response to the owning core
//   oob_cnt                                        saturating count of accepted out-of-range requests
//   mem_write_en/mem_addr/mem_data_in/mem_data_out single-port DRAM, 1-cycle read
//   RESP_REG_EN defined: responses registered one more edge (read latency 3 instead of 2)
module dram_access_master
  import dram_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  output logic [NUM_CORES-1:0]        req_ready,
  input  logic [NUM_CORES-1:0]        req_we,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic                        resp_err,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic [15:0]                 oob_cnt,
  output logic                        mem_write_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out
);
  core_t k;
  logic acc, oob, we_k;
  logic [ADDR_W-1:0] addr_k, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_k, mem_din_q, mem_din_d, rsp_rdata_d;
  logic mem_we_q, mem_we_d, rsp_err_d;
  logic [NUM_CORES-1:0] rsp_valid_d;
  logic [15:0] oob_cnt_q, oob_cnt_d;
  rd_tag_t s1_q, s1_d, s2_q, s2_d;
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .advance  (|req_valid),
    .grant    (req_ready),
    .grant_idx(k)
  );
  always_comb begin
    acc = |req_ready;
    addr_k = req_addr[k*ADDR_W +: ADDR_W];
    wdata_k = req_wdata[k*DATA_W +: DATA_W];
    we_k = req_we[k];
    oob = addr_k >= ADDR_W'(MEM_DEPTH);
    mem_we_d = acc & we_k & ~oob;
    mem_addr_d = acc ? addr_k : mem_addr_q;
    mem_din_d = acc ? wdata_k : mem_din_q;
    s1_d = '{v: acc & ~we_k, core: k, err: oob};
    s2_d = s1_q;
    oob_cnt_d = oob_cnt_q + 16'(acc && oob && oob_cnt_q != 16'hFFFF);
    // stage2 lines up with mem_data_out, which the DRAM refreshed on the same edge
    rsp_valid_d = s2_q.v ? NUM_CORES'(1) << s2_q.core : '0;
    rsp_err_d = s2_q.v & s2_q.err;
    rsp_rdata_d = (s2_q.v && !s2_q.err) ? mem_data_out : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      oob_cnt_q <= '0;
    end else begin
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      oob_cnt_q <= oob_cnt_d;
    end
`ifdef RESP_REG_EN
  logic [NUM_CORES-1:0] rsp_valid_q;
  logic rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  assign resp_valid = rsp_valid_q;
  assign resp_err = rsp_err_q;
  assign resp_rdata = rsp_rdata_q;
`else
  assign resp_valid = rsp_valid_d;
  assign resp_err = rsp_err_d;
  assign resp_rdata = rsp_rdata_d;
`endif
  assign mem_write_en = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data_in = mem_din_q;
  assign oob_cnt = oob_cnt_q;
endmodule

// File: tb/tb_dram_access_master.sv
// tb_dram_access_master: directed table plus randomized traffic against a queue-based reference model
module tb_dram_access_master;
`ifdef RESP_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_ready, req_we = '0, resp_valid;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic resp_err, mem_write_en;
  logic [15:0] resp_rdata, oob_cnt, mem_addr, mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic [15:0] dmem [0:1024] = '{default: 16'h0};
  dram_access_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .oob_cnt(oob_cnt), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_write_en && mem_addr < 16'd1025) dmem[mem_addr] <= mem_data_in;
    mem_data_out <= (mem_addr < 16'd1025) ? dmem[mem_addr] : 16'hDEAD;
  end
  typedef struct {
    logic rst_n;
    logic [3:0] valid, we;
    logic [63:0] addr, wdata;
    logic [3:0] exp_ready;
    logic [15:0] exp_oob;
  } vec_t;
  typedef struct {
    int due;
    int core;
    logic err;
    logic [15:0] data;
  } rsp_t;
  int checks = 0, errors = 0, cyc = 0, ptr = 0;
  logic [15:0] ref_mem [0:1024];
  logic exp_mwe = 1'b0;
  logic [15:0] exp_maddr = '0, exp_mdin = '0, exp_oob = '0;
  rsp_t q[$];
  vec_t tbl[24];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", n, cyc, a, e);
    end
  endtask
  function automatic logic [3:0] rr(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return 4'b1 << ((p + i) % 4);
    return 4'b0;
  endfunction
  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] w,
                              input logic [63:0] a, input logic [63:0] d,
                              input logic [3:0] er, input logic [15:0] eo);
    vec_t t;
    t.rst_n = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d; t.exp_ready = er; t.exp_oob = eo;
    return t;
  endfunction
  task automatic step(input vec_t t, input logic use_tbl);
    logic [3:0] er, e_rv;
    logic e_err, bad;
    logic [15:0] e_rd, a, w;
    int k;
    rsp_t r;
    @(posedge clk);
    #1;
    rst_n = t.rst_n; req_valid = t.valid; req_we = t.we; req_addr = t.addr; req_wdata = t.wdata;
    cyc++;
    if (!t.rst_n) begin
      ptr = 0; q.delete(); exp_mwe = 0; exp_maddr = 0; exp_mdin = 0; exp_oob = 0;
    end
    @(negedge clk);
    er = rr(t.valid, ptr);
    e_rv = 0; e_err = 0; e_rd = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      e_rv = 4'b1 << r.core; e_err = r.err; e_rd = r.data;
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("resp_valid", 64'(resp_valid), 64'(e_rv));
    chk("resp_err", 64'(resp_err), 64'(e_err));
    chk("resp_rdata", 64'(resp_rdata), 64'(e_rd));
    chk("mem_write_en", 64'(mem_write_en), 64'(exp_mwe));
    chk("mem_addr", 64'(mem_addr), 64'(exp_maddr));
    chk("mem_data_in", 64'(mem_data_in), 64'(exp_mdin));
    chk("oob_cnt", 64'(oob_cnt), 64'(exp_oob));
    if (use_tbl) begin
      chk("tbl_ready", 64'(req_ready), 64'(t.exp_ready));
      chk("tbl_oob", 64'(oob_cnt), 64'(t.exp_oob));
    end
    exp_mwe = 0;
    if (t.rst_n && er != 0) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (er[i]) k = i;
      a = t.addr[k*16 +: 16];
      w = t.wdata[k*16 +: 16];
      bad = a >= 16'd1025;
      if (bad && exp_oob != 16'hFFFF) exp_oob++;
      if (t.we[k]) begin
        if (!bad) ref_mem[a] = w;
      end else q.push_back('{cyc + LAT, k, bad, bad ? 16'h0 : ref_mem[a]});
      exp_mwe = t.we[k] & ~bad;
      exp_maddr = a;
      exp_mdin = w;
      ptr = (k + 1) % 4;
    end
  endtask
  initial begin
    vec_t v;
    logic [63:0] a;
    for (int i = 0; i < 1025; i++) ref_mem[i] = 16'h0;
    tbl[0]  = mk(0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    tbl[1]  = mk(0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    tbl[2]  = mk(1, 4'h1, 4'h1, 64'd10, 64'h00AB, 4'h1, 16'd0);
    tbl[3]  = mk(1, 4'h1, 4'h0, 64'd10, 64'h0, 4'h1, 16'd0);
    tbl[4]  = mk(1, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    tbl[5]  = mk(1, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    tbl[6]  = mk(0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    for (int i = 0; i < 8; i++)
      tbl[7+i] = mk(1, 4'hF, 4'h0, {16'd4, 16'd3, 16'd2, 16'd1}, 64'h0, 4'b1 << (i % 4), 16'd0);
    tbl[15] = mk(1, 4'h4, 4'h0, {16'd0, 16'd1025, 32'd0}, 64'h0, 4'h4, 16'd0);
    tbl[16] = mk(1, 4'h2, 4'h2, {32'd0, 16'd2000, 16'd0}, {32'd0, 16'h5555, 16'd0}, 4'h2, 16'd1);
    tbl[17] = mk(1, 4'h2, 4'h2, {32'd0, 16'd7, 16'd0}, {32'd0, 16'h1234, 16'd0}, 4'h2, 16'd2);
    tbl[18] = mk(1, 4'h8, 4'h0, {16'd7, 48'd0}, 64'h0, 4'h8, 16'd2);
    tbl[19] = mk(1, 4'h1, 4'h0, 64'd5, 64'h0, 4'h1, 16'd2);
    tbl[20] = mk(0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    for (int i = 21; i < 24; i++) tbl[i] = mk(1, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0);
    for (int i = 0; i < 24; i++) step(tbl[i], 1'b1);
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++)
        a[c*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1020, 1030))
                                                     : 16'($urandom_range(0, 31));
      v = mk(1, 4'($urandom), 4'($urandom), a, {$urandom, $urandom}, 4'h0, 16'd0);
      step(v, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(mk(1, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 16'd0), 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending responses got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
